interrupt_controller: RTL and testbench

Collects the microcontroller's interrupt sources (int_ext1, int_ext2, TIM1/TIM2 compare events) and presents one prioritised interrupt to the CPU core through a request/acknowledge/done handshake. Software configures it through a small memory-mapped register window on the peripheral bus. Sits between the external-interrupt pins/timer blocks and the core's trap logic inside microcontroller.

---
 rtl/interrupt_controller.sv | 156 +++++++++++++++
 tb/tb_interrupt_controller.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - prioritised interrupt controller with register window and req/ack/done handshake
module interrupt_controller #(
    parameter int NUM_SOURCES = 4,
    parameter int ID_WIDTH    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] src_in,
    input  logic [1:0]             reg_addr,
    input  logic [31:0]            reg_wdata,
    input  logic                   reg_we,
    input  logic                   reg_re,
    output logic [31:0]            reg_rdata,
    output logic                   irq_req,
    output logic [ID_WIDTH-1:0]    irq_id,
    input  logic                   irq_ack,
    input  logic                   irq_done,
    output logic                   irq_active
);

    localparam int N = NUM_SOURCES;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_e;

    logic [N-1:0]        sync1_q, sync2_q, syncd_q;
    logic [N-1:0]        enable_q, enable_d;
    logic [N-1:0]        pending_q, pending_d;
    logic [N-1:0]        edge_sel_q, edge_sel_d;
    state_e              state_q, state_d;
    logic [ID_WIDTH-1:0] irq_id_q, irq_id_d;
    logic                irq_req_q, irq_active_q;
    logic [31:0]         rdata_q, rdata_d;

    logic                wr_enable, wr_pending, wr_edge_sel;
    logic [N-1:0]        rise, w1c, to_edge, ack_clr, edge_next, level_next;
    logic [N-1:0]        eligible, id_onehot;
    logic                any_eligible;
    logic [ID_WIDTH-1:0] winner;
    logic [31:0]         rd_val;
    logic                unused_wdata;

    assign unused_wdata = ^reg_wdata[31:N];

    assign wr_enable   = reg_we && (reg_addr == 2'd0);
    assign wr_pending  = reg_we && (reg_addr == 2'd1);
    assign wr_edge_sel = reg_we && (reg_addr == 2'd2);

    assign rise         = sync2_q & ~syncd_q;
    assign eligible     = pending_q & enable_q;
    assign any_eligible = |eligible;
    assign id_onehot    = N'(1) << irq_id_q;

    // Lowest-index eligible source wins
    always_comb begin
        winner = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_WIDTH'(i);
            end
        end
    end

    // Handshake FSM: next state, id capture and the ack-driven pending clear
    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        ack_clr  = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_eligible) begin
                    state_d  = ST_REQUEST;
                    irq_id_d = winner;
                end
            end
            ST_REQUEST: begin
                if (irq_ack) begin
                    state_d = ST_ACTIVE;
                    ack_clr = id_onehot;
                end else if (!(|(eligible & id_onehot))) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (irq_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pending update: edge bits latch rising edges (set beats clear), level bits follow the synchronised line
    always_comb begin
        w1c        = wr_pending ? reg_wdata[N-1:0] : '0;
        to_edge    = wr_edge_sel ? (reg_wdata[N-1:0] & ~edge_sel_q) : '0;
        edge_next  = rise | (pending_q & ~(w1c | ack_clr));
        level_next = (sync2_q & ~to_edge) | (rise & to_edge);
        pending_d  = (edge_sel_q & edge_next) | (~edge_sel_q & level_next);
        enable_d   = wr_enable ? reg_wdata[N-1:0] : enable_q;
        edge_sel_d = wr_edge_sel ? reg_wdata[N-1:0] : edge_sel_q;
    end

    // Read mux samples pre-write state so a simultaneous write is not visible
    always_comb begin
        rd_val = '0;
        case (reg_addr)
            2'd0: rd_val[N-1:0] = enable_q;
            2'd1: rd_val[N-1:0] = pending_q;
            2'd2: rd_val[N-1:0] = edge_sel_q;
            default: begin
                rd_val[31]           = any_eligible;
                rd_val[ID_WIDTH-1:0] = winner;
            end
        endcase
        rdata_d = reg_re ? rd_val : rdata_q;
    end

    // State registers, synchronisers and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            syncd_q      <= '0;
            enable_q     <= '0;
            pending_q    <= '0;
            edge_sel_q   <= '1;
            state_q      <= ST_IDLE;
            irq_id_q     <= '0;
            irq_req_q    <= 1'b0;
            irq_active_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            sync1_q      <= src_in;
            sync2_q      <= sync1_q;
            syncd_q      <= sync2_q;
            enable_q     <= enable_d;
            pending_q    <= pending_d;
            edge_sel_q   <= edge_sel_d;
            state_q      <= state_d;
            irq_id_q     <= irq_id_d;
            irq_req_q    <= (state_d == ST_REQUEST);
            irq_active_q <= (state_d == ST_ACTIVE);
            rdata_q      <= rdata_d;
        end
    end

    assign reg_rdata  = rdata_q;
    assign irq_req    = irq_req_q;
    assign irq_id     = irq_id_q;
    assign irq_active = irq_active_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - scoreboard bench for interrupt_controller
module tb_interrupt_controller;

    localparam int NS   = 4;
    localparam int IW   = 2;
    localparam int MASK = (1 << NS) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [NS-1:0] src_in;
    logic [1:0]    reg_addr;
    logic [31:0]   reg_wdata;
    logic          reg_we, reg_re;
    logic [31:0]   reg_rdata;
    logic          irq_req;
    logic [IW-1:0] irq_id;
    logic          irq_ack, irq_done, irq_active;

    always #5 clk = ~clk;

    interrupt_controller #(.NUM_SOURCES(NS), .ID_WIDTH(IW)) dut (
        .clk        (clk),
        .reset      (reset),
        .src_in     (src_in),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
        .irq_req    (irq_req),
        .irq_id     (irq_id),
        .irq_ack    (irq_ack),
        .irq_done   (irq_done),
        .irq_active (irq_active)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd_q[$];
    int          irq_q[$];
    bit          mon_en = 1'b0;
    int          cur_src = 0;

    // reference model: 0 idle, 1 request, 2 active; src_hist holds the line as seen 1,2,3 edges ago
    int m_en, m_pend, m_edge, m_state, m_id;
    int src_hist[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_winner();
        int e;
        e = m_pend & m_en;
        for (int i = 0; i < NS; i++) begin
            if (e[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_en = 0; m_pend = 0; m_edge = MASK; m_state = 0; m_id = 0;
        for (int i = 0; i < 3; i++) src_hist[i] = 0;
        rd_q.delete();
        irq_q.delete();
    endtask

    task automatic model_step(input int src, input bit we, input bit re, input int addr,
                              input logic [31:0] wdata, input bit ack, input bit done);
        int          e, nstate, ack_clr, npend;
        bit          now_hi, was_hi, rise, clr, nb;
        logic [31:0] c;
        e = m_pend & m_en;
        if (re) begin
            c = '0;
            case (addr)
                0: c = 32'(m_en);
                1: c = 32'(m_pend);
                2: c = 32'(m_edge);
                default: if (e != 0) begin c[31] = 1'b1; c[IW-1:0] = IW'(m_winner()); end
            endcase
            rd_q.push_back(c);
        end
        nstate = m_state;
        ack_clr = 0;
        if (m_state == 0) begin
            if (e != 0) begin
                nstate = 1;
                m_id = m_winner();
                irq_q.push_back(m_id);
            end
        end else if (m_state == 1) begin
            if (ack) begin
                nstate = 2;
                ack_clr = 1 << m_id;
            end else if (((e >> m_id) & 1) == 0) begin
                nstate = 0;
            end
        end else if (done) begin
            nstate = 0;
        end
        npend = 0;
        for (int i = 0; i < NS; i++) begin
            now_hi = ((src_hist[1] >> i) & 1) != 0;
            was_hi = ((src_hist[2] >> i) & 1) != 0;
            rise   = now_hi && !was_hi;
            if (((m_edge >> i) & 1) != 0) begin
                clr = (we && addr == 1 && wdata[i]) || (((ack_clr >> i) & 1) != 0);
                nb  = rise || ((((m_pend >> i) & 1) != 0) && !clr);
            end else if (we && addr == 2 && wdata[i]) begin
                nb = rise;
            end else begin
                nb = now_hi;
            end
            if (nb) npend |= (1 << i);
        end
        m_pend  = npend;
        m_state = nstate;
        if (we && addr == 0) m_en   = int'(wdata) & MASK;
        if (we && addr == 2) m_edge = int'(wdata) & MASK;
        src_hist[2] = src_hist[1];
        src_hist[1] = src_hist[0];
        src_hist[0] = src & MASK;
    endtask

    task automatic cyc(input bit we, input bit re, input int addr, input logic [31:0] wdata,
                       input bit ack, input bit done);
        @(negedge clk);
        src_in    = cur_src[NS-1:0];
        reg_we    = we;
        reg_re    = re;
        reg_addr  = addr[1:0];
        reg_wdata = wdata;
        irq_ack   = ack;
        irq_done  = done;
        model_step(cur_src, we, re, addr, wdata, ack, done);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic wr(input int addr, input logic [31:0] d);
        cyc(1'b1, 1'b0, addr, d, 1'b0, 1'b0);
    endtask

    task automatic rd(input int addr, output logic [31:0] v);
        cyc(1'b0, 1'b1, addr, 32'h0, 1'b0, 1'b0);
        v = reg_rdata;
    endtask

    task automatic release_reset();
        @(negedge clk);
        cur_src = 0;
        src_in = '0; reg_we = 1'b0; reg_re = 1'b0; reg_addr = '0; reg_wdata = '0;
        irq_ack = 1'b0; irq_done = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        model_step(0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    // monitor: pops expected read data and request ids when the DUT presents them, tracks handshake levels
    bit prev_req = 1'b0;
    always begin
        bit re_s;
        @(posedge clk);
        re_s = reg_re;
        #1;
        if (mon_en && reset) begin
            if (re_s) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_q_underflow: got read data 0x%0h expected none", reg_rdata);
                end else begin
                    chk("reg_rdata", reg_rdata, rd_q.pop_front());
                end
            end
            if (irq_req && !prev_req) begin
                if (irq_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL irq_q_underflow: got request id %0d expected none", irq_id);
                end else begin
                    chk("irq_id_at_req", 32'(irq_id), 32'(irq_q.pop_front()));
                end
            end
            chk("irq_req_level", 32'(irq_req), 32'(m_state == 1));
            chk("irq_active_level", 32'(irq_active), 32'(m_state == 2));
            chk("irq_id_level", 32'(irq_id), 32'(m_id));
        end
        prev_req = irq_req;
    end

    initial begin
        logic [31:0] v;
        reset = 1'b0;
        src_in = '0; reg_we = 1'b0; reg_re = 1'b0; reg_addr = '0; reg_wdata = '0;
        irq_ack = 1'b0; irq_done = 1'b0;
        model_reset();
        #1;
        chk("rst_irq_req", 32'(irq_req), 32'h0);
        chk("rst_irq_active", 32'(irq_active), 32'h0);
        chk("rst_irq_id", 32'(irq_id), 32'h0);
        chk("rst_rdata", reg_rdata, 32'h0);
        release_reset();
        rd(2, v); chk("rst_edge_sel", v, 32'hF);
        rd(0, v); chk("rst_enable", v, 32'h0);

        // single edge on source 2: request three edges after the pulse
        wr(0, 32'hF);
        cur_src = 4; idle();
        cur_src = 0; idle();
        idle();
        chk("t1_req_at_n2", 32'(irq_req), 32'h0);
        idle();
        chk("t1_req_at_n3", 32'(irq_req), 32'h1);
        chk("t1_id_at_n3", 32'(irq_id), 32'h2);
        rd(1, v); chk("t1_pending", v, 32'h4);
        rd(3, v); chk("t1_claim", v, 32'h8000_0002);
        cyc(1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0);
        chk("t1_active", 32'(irq_active), 32'h1);
        rd(1, v); chk("t1_pending_after_ack", v, 32'h0);
        cyc(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b1);
        idle();
        chk("t1_idle_after_done", 32'(irq_req), 32'h0);

        // sources 1 and 3 together: 1 first, 3 after done
        cur_src = 32'hA; idle();
        cur_src = 0; idle(); idle(); idle();
        chk("t2_id_first", 32'(irq_id), 32'h1);
        cyc(1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0);
        chk("t2_active", 32'(irq_active), 32'h1);
        rd(1, v); chk("t2_pending", v, 32'h8);
        cyc(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b1);
        chk("t2_idle_gap", 32'(irq_req), 32'h0);
        idle();
        chk("t2_req_second", 32'(irq_req), 32'h1);
        chk("t2_id_second", 32'(irq_id), 32'h3);
        cyc(1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b1);

        // withdrawal by disabling the requested source
        cur_src = 1; idle();
        cur_src = 0; idle(); idle(); idle();
        chk("t3_req", 32'(irq_req), 32'h1);
        wr(0, 32'h0);
        idle();
        chk("t3_withdrawn", 32'(irq_req), 32'h0);
        rd(1, v); chk("t3_pending_kept", v, 32'h1);
        wr(1, 32'h1);
        wr(0, 32'hF);

        // source 0 in level mode held high
        wr(2, 32'hE);
        cur_src = 1; idle(); idle(); idle(); idle();
        chk("t4_req", 32'(irq_req), 32'h1);
        wr(1, 32'h1);
        rd(1, v); chk("t4_w1c_ignored", v, 32'h1);
        cyc(1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b1);
        idle();
        chk("t4_rereq", 32'(irq_req), 32'h1);
        chk("t4_rereq_id", 32'(irq_id), 32'h0);
        cur_src = 0;
        cyc(1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0);
        idle(); idle();
        cyc(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b1);
        idle();
        chk("t4_released", 32'(irq_req), 32'h0);
        wr(2, 32'hF);

        // W1C racing a fresh edge on source 1: set wins
        wr(0, 32'h0);
        cur_src = 2; idle();
        cur_src = 0; idle(); idle();
        cur_src = 2; idle();
        cur_src = 0; idle();
        wr(1, 32'h2);
        rd(1, v); chk("t5_set_wins", v, 32'h2);
        wr(1, 32'h2);
        rd(1, v); chk("t5_cleared", v, 32'h0);
        wr(0, 32'hF);

        // asynchronous reset while a handler is active
        rd(2, v); chk("t6_edge_sel", v, 32'hF);
        cur_src = 1; idle();
        cur_src = 0; idle(); idle(); idle();
        cyc(1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0);
        chk("t6_active", 32'(irq_active), 32'h1);
        #1;
        mon_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_active", 32'(irq_active), 32'h0);
        chk("t6_async_req", 32'(irq_req), 32'h0);
        chk("t6_async_rdata", reg_rdata, 32'h0);
        release_reset();
        rd(0, v); chk("t6_enable", v, 32'h0);
        rd(2, v); chk("t6_edge_sel_after", v, 32'hF);

        // randomized traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            bit we, re, ack, done;
            int addr;
            logic [31:0] wd;
            if ($urandom_range(0, 3) == 0) cur_src = int'($urandom_range(0, MASK));
            we   = ($urandom_range(0, 7) == 0);
            re   = ($urandom_range(0, 3) == 0);
            addr = int'($urandom_range(0, 3));
            wd   = $urandom;
            if (we && addr == 0 && $urandom_range(0, 1) == 0) wd = 32'hFFFF_FFFF;
            ack  = ($urandom_range(0, 2) == 0);
            done = ($urandom_range(0, 3) == 0);
            cyc(we, re, addr, wd, ack, done);
            if (i == 2000) begin
                #1;
                mon_en = 1'b0;
                reset = 1'b0;
                #1;
                chk("rand_async_req", 32'(irq_req), 32'h0);
                chk("rand_async_active", 32'(irq_active), 32'h0);
                release_reset();
            end
        end
        idle();
        #2;
        chk("rd_q_drained", 32'(rd_q.size()), 32'h0);
        chk("irq_q_drained", 32'(irq_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
